// File: rtl/ysyx_22041211_lsu_wb.sv
// Load/store and write-back stage. It handles one instruction at a time over a valid/ready
// memory bus, with byte-lane steering, misalignment trapping and a response timeout.
module ysyx_22041211_lsu_wb #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  wb_ready_o,
    input  logic                  wd_i,
    input  logic [4:0]            wreg_i,
    input  logic [DATA_LEN-1:0]   alu_result_i,
    input  logic [DATA_LEN-1:0]   mem_wdata_i,
    input  logic [2:0]            load_type_i,
    input  logic [1:0]            store_type_i,
    input  logic [DATA_LEN-1:0]   csr_wdata_i,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_LEN-1:0]   mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_LEN-1:0]   mem_req_wdata,
    output logic [DATA_LEN/8-1:0] mem_req_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_LEN-1:0]   mem_rsp_rdata,
    input  logic                  mem_rsp_err,
    output logic                  wb_valid_o,
    output logic                  wd_o,
    output logic [4:0]            wreg_o,
    output logic [DATA_LEN-1:0]   wdata_o,
    output logic [DATA_LEN-1:0]   csr_wdata_o,
    output logic                  finish,
    output logic                  exc_o,
    output logic [1:0]            exc_cause_o
);
    localparam int STRB = DATA_LEN / 8;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
    state_t state, state_nx;

    logic [7:0]          cnt;
    logic                wd_r;
    logic [4:0]          wreg_r;
    logic [DATA_LEN-1:0] alu_r, wdat_r, csr_r;
    logic [2:0]          ld_r;
    logic [1:0]          st_r;

    logic [1:0]          off_in;
    logic                mis_in, mem_in;
    logic [DATA_LEN-1:0] shifted, ext;
    logic [ADDR_LEN-1:0] addr_w;

    logic                cm_en, cm_wd;
    logic [4:0]          cm_wreg;
    logic [DATA_LEN-1:0] cm_data, cm_csr;
    logic [1:0]          cm_cause;

    assign off_in = alu_result_i[1:0];
    assign mis_in = ((load_type_i == 3'd2 || load_type_i == 3'd5 || store_type_i == 2'd2) && off_in == 2'd3)
                 || ((load_type_i == 3'd3 || store_type_i == 2'd3) && off_in != 2'd0);
    assign mem_in = (load_type_i != 3'd0) || (store_type_i != 2'd0);

    // Read data arrives as a full word; bring the addressed byte/half down to lane 0.
    assign shifted = mem_rsp_rdata >> {alu_r[1:0], 3'b000};
    always_comb begin
        ext = shifted;
        case (ld_r)
            3'd1:    ext = {{(DATA_LEN-8){shifted[7]}}, shifted[7:0]};
            3'd2:    ext = {{(DATA_LEN-16){shifted[15]}}, shifted[15:0]};
            3'd4:    ext = {{(DATA_LEN-8){1'b0}}, shifted[7:0]};
            3'd5:    ext = {{(DATA_LEN-16){1'b0}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign addr_w        = ADDR_LEN'(alu_r);
    assign mem_req_addr  = {addr_w[ADDR_LEN-1:2], 2'b00};
    assign mem_req_wdata = wdat_r << {alu_r[1:0], 3'b000};
    assign mem_req_wen   = (st_r != 2'd0);
    assign mem_req_valid = (state == REQ);

    always_comb begin
        mem_req_wstrb = '0;
        case (st_r)
            2'd1:    mem_req_wstrb = STRB'(4'b0001) << alu_r[1:0];
            2'd2:    mem_req_wstrb = STRB'(4'b0011) << alu_r[1:0];
            2'd3:    mem_req_wstrb = STRB'(4'b1111);
            default: mem_req_wstrb = '0;
        endcase
    end

    // The commit values are computed on the transition into DONE and registered there.
    always_comb begin
        state_nx = state;
        cm_en    = 1'b0;
        cm_wd    = 1'b0;
        cm_wreg  = wreg_r;
        cm_data  = alu_r;
        cm_csr   = csr_r;
        cm_cause = 2'd0;
        case (state)
            IDLE: if (exu_valid) begin
                cm_wreg = wreg_i;
                cm_data = alu_result_i;
                cm_csr  = csr_wdata_i;
                if (mis_in) begin
                    state_nx = DONE;
                    cm_en    = 1'b1;
                    cm_cause = 2'd1;
                end else if (mem_in) begin
                    state_nx = REQ;
                end else begin
                    state_nx = DONE;
                    cm_en    = 1'b1;
                    cm_wd    = wd_i;
                end
            end
            REQ: if (mem_req_ready) state_nx = RSP;
            RSP: begin
                if (mem_rsp_valid) begin
                    state_nx = DONE;
                    cm_en    = 1'b1;
                    cm_data  = (ld_r != 3'd0) ? ext : alu_r;
                    cm_wd    = wd_r & ~mem_rsp_err;
                    cm_cause = mem_rsp_err ? 2'd2 : 2'd0;
                end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                    state_nx = DONE;
                    cm_en    = 1'b1;
                    cm_cause = 2'd3;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            wd_r   <= 1'b0;
            wreg_r <= '0;
            alu_r  <= '0;
            wdat_r <= '0;
            csr_r  <= '0;
            ld_r   <= '0;
            st_r   <= '0;
        end else begin
            cnt <= (state == RSP && state_nx == RSP) ? cnt + 8'd1 : 8'd0;
            if (state == IDLE && exu_valid) begin
                wd_r   <= wd_i;
                wreg_r <= wreg_i;
                alu_r  <= alu_result_i;
                wdat_r <= mem_wdata_i;
                csr_r  <= csr_wdata_i;
                ld_r   <= load_type_i;
                st_r   <= store_type_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_o        <= 1'b0;
            wreg_o      <= '0;
            wdata_o     <= '0;
            csr_wdata_o <= '0;
            exc_cause_o <= '0;
        end else if (cm_en) begin
            wd_o        <= cm_wd;
            wreg_o      <= cm_wreg;
            wdata_o     <= cm_data;
            csr_wdata_o <= cm_csr;
            exc_cause_o <= cm_cause;
        end
    end

    assign wb_ready_o = (state == IDLE);
    assign wb_valid_o = (state == DONE);
    assign finish     = (state == DONE);
    assign exc_o      = (state == DONE) && (exc_cause_o != 2'd0);
endmodule

// File: tb/tb_ysyx_22041211_lsu_wb.sv
// Directed bench for the LSU/write-back stage: ALU commit, load lanes, stalled store,
// misalignment, timeout, bus error and asynchronous reset.
module tb_ysyx_22041211_lsu_wb;
    logic        clk, rst;
    logic        exu_valid, wb_ready_o, wd_i;
    logic [4:0]  wreg_i;
    logic [31:0] alu_result_i, mem_wdata_i, csr_wdata_i;
    logic [2:0]  load_type_i;
    logic [1:0]  store_type_i;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_rdata;
    logic        wb_valid_o, wd_o, finish, exc_o;
    logic [4:0]  wreg_o;
    logic [31:0] wdata_o, csr_wdata_o;
    logic [1:0]  exc_cause_o;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22041211_lsu_wb #(.DATA_LEN(32), .ADDR_LEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .exu_valid(exu_valid), .wb_ready_o(wb_ready_o),
        .wd_i(wd_i), .wreg_i(wreg_i), .alu_result_i(alu_result_i), .mem_wdata_i(mem_wdata_i),
        .load_type_i(load_type_i), .store_type_i(store_type_i), .csr_wdata_i(csr_wdata_i),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .wb_valid_o(wb_valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .csr_wdata_o(csr_wdata_o), .finish(finish), .exc_o(exc_o), .exc_cause_o(exc_cause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic wd, input logic [4:0] wreg);
        exu_valid    = 1'b1;
        load_type_i  = ld;
        store_type_i = st;
        alu_result_i = addr;
        mem_wdata_i  = wdat;
        wd_i         = wd;
        wreg_i       = wreg;
        csr_wdata_i  = addr ^ 32'h5A5A_5A5A;
        tick();
        exu_valid    = 1'b0;
        load_type_i  = '0;
        store_type_i = '0;
    endtask

    // Zero-wait load: REQ one cycle, response on the first RSP cycle.
    task automatic do_load(input string tag, input logic [2:0] ld, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        mem_req_ready = 1'b1;
        issue(ld, 2'd0, addr, 32'h0, 1'b1, 5'd9);
        chk({tag, "_req_v"}, 32'(mem_req_valid), 32'd1);
        chk({tag, "_addr"}, mem_req_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "_wstrb"}, 32'(mem_req_wstrb), 32'd0);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        tick();
        mem_rsp_valid = 1'b0;
        chk({tag, "_wbv"}, 32'(wb_valid_o), 32'd1);
        chk({tag, "_data"}, wdata_o, exp);
        chk({tag, "_wd"}, 32'(wd_o), 32'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1; exu_valid = 1'b0; wd_i = 1'b0; wreg_i = '0; alu_result_i = '0;
        mem_wdata_i = '0; load_type_i = '0; store_type_i = '0; csr_wdata_i = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
        #22;
        chk("rst_ready", 32'(wb_ready_o), 32'd1);
        chk("rst_reqv", 32'(mem_req_valid), 32'd0);
        chk("rst_wbv", 32'(wb_valid_o), 32'd0);
        chk("rst_exc", {29'd0, exc_o, exc_cause_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        rst = 1'b0;
        tick();

        // ALU op commits one cycle after accept
        issue(3'd0, 2'd0, 32'h1234, 32'h0, 1'b1, 5'd5);
        chk("alu_wbv", 32'(wb_valid_o), 32'd1);
        chk("alu_fin", 32'(finish), 32'd1);
        chk("alu_wd", 32'(wd_o), 32'd1);
        chk("alu_wreg", 32'(wreg_o), 32'd5);
        chk("alu_wdata", wdata_o, 32'h1234);
        chk("alu_csr", csr_wdata_o, 32'h1234 ^ 32'h5A5A_5A5A);
        chk("alu_noreq", 32'(mem_req_valid), 32'd0);
        chk("alu_busy", 32'(wb_ready_o), 32'd0);
        tick();
        chk("alu_pulse", 32'(wb_valid_o), 32'd0);
        chk("alu_hold", wdata_o, 32'h1234);
        chk("alu_ready", 32'(wb_ready_o), 32'd1);

        do_load("lb",  3'd1, 32'h8000_0003, 32'h80FF_FFFF, 32'hFFFF_FF80);
        do_load("lbu", 3'd4, 32'h8000_0003, 32'h80FF_FFFF, 32'h0000_0080);
        do_load("lh",  3'd2, 32'h8000_0002, 32'h8001_7777, 32'hFFFF_8001);
        do_load("lhu", 3'd5, 32'h8000_0002, 32'h8001_7777, 32'h0000_8001);
        do_load("lw",  3'd3, 32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // SH with ready held low for 3 cycles
        mem_req_ready = 1'b0;
        issue(3'd0, 2'd2, 32'h8000_0002, 32'hABCD_1234, 1'b0, 5'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sh_v%0d", i), 32'(mem_req_valid), 32'd1);
            chk($sformatf("sh_a%0d", i), mem_req_addr, 32'h8000_0000);
            chk($sformatf("sh_s%0d", i), 32'(mem_req_wstrb), 32'hC);
            chk($sformatf("sh_d%0d", i), mem_req_wdata, 32'h1234_0000);
            chk($sformatf("sh_w%0d", i), 32'(mem_req_wen), 32'd1);
            if (i == 3) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        chk("sh_rsp_noreq", 32'(mem_req_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        chk("sh_wbv", 32'(wb_valid_o), 32'd1);
        chk("sh_wd", 32'(wd_o), 32'd0);
        chk("sh_exc", 32'(exc_o), 32'd0);
        tick();

        // Misaligned LW: no request, exception next cycle
        issue(3'd3, 2'd0, 32'h8000_0001, 32'h0, 1'b1, 5'd3);
        chk("mis_noreq", 32'(mem_req_valid), 32'd0);
        chk("mis_wbv", 32'(wb_valid_o), 32'd1);
        chk("mis_exc", 32'(exc_o), 32'd1);
        chk("mis_cause", 32'(exc_cause_o), 32'd1);
        chk("mis_wd", 32'(wd_o), 32'd0);
        tick();
        chk("mis_pulse", 32'(exc_o), 32'd0);

        // Timeout after 4 RSP cycles, late response ignored
        mem_req_ready = 1'b1;
        issue(3'd3, 2'd0, 32'h8000_0010, 32'h0, 1'b1, 5'd6);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_wait%0d", i), 32'(wb_valid_o), 32'd0);
            tick();
        end
        chk("to_wbv", 32'(wb_valid_o), 32'd1);
        chk("to_exc", 32'(exc_o), 32'd1);
        chk("to_cause", 32'(exc_cause_o), 32'd3);
        chk("to_wd", 32'(wd_o), 32'd0);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        chk("to_late_wbv", 32'(wb_valid_o), 32'd0);
        chk("to_late_rdy", 32'(wb_ready_o), 32'd1);
        tick();
        chk("to_late_wbv2", 32'(wb_valid_o), 32'd0);

        // Response during request acceptance is not sampled; then bus error
        issue(3'd3, 2'd0, 32'h8000_0020, 32'h0, 1'b1, 5'd8);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        chk("err_early", 32'(wb_valid_o), 32'd0);
        tick();
        chk("err_wait", 32'(wb_valid_o), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        chk("err_wbv", 32'(wb_valid_o), 32'd1);
        chk("err_cause", 32'(exc_cause_o), 32'd2);
        chk("err_exc", 32'(exc_o), 32'd1);
        chk("err_wd", 32'(wd_o), 32'd0);
        chk("err_wreg", 32'(wreg_o), 32'd8);
        tick();

        // Async reset in RSP
        issue(3'd3, 2'd0, 32'h8000_0030, 32'h0, 1'b1, 5'd11);
        tick();
        chk("ar_busy", 32'(wb_ready_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("ar_ready", 32'(wb_ready_o), 32'd1);
        chk("ar_reqv", 32'(mem_req_valid), 32'd0);
        chk("ar_wreg", 32'(wreg_o), 32'd0);
        chk("ar_wdata", wdata_o, 32'd0);
        chk("ar_csr", csr_wdata_o, 32'd0);
        chk("ar_cause", 32'(exc_cause_o), 32'd0);
        chk("ar_flags", {28'd0, wb_valid_o, finish, exc_o, wd_o}, 32'd0);
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        chk("ar_ignore", 32'(wb_valid_o), 32'd0);
        chk("ar_idle", 32'(wb_ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
